// File: rtl/fifo_pkt_writer.sv
// Write-side packet framer for async_fifo: emits header, payload words and trailer,
// each tagged with a 2-bit type, through a single registered output slot.
module fifo_pkt_writer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH+1:0] fifo_din,
  input  logic                  fifo_full,
  output logic                  busy,
  output logic [15:0]           pkt_cnt
);

  localparam logic [1:0] TagData = 2'b00;
  localparam logic [1:0] TagHdr  = 2'b01;
  localparam logic [1:0] TagTrl  = 2'b11;

  typedef enum logic [1:0] {StIdle, StData, StTrl} state_e;

  state_e                state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH+1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] seq_q, seq_d;
  logic [DATA_WIDTH-1:0] len_q, len_d;
  logic [15:0]           pkt_cnt_q, pkt_cnt_d;

  logic accept;
  logic slot_free;

  assign accept    = wr_en_q & ~fifo_full;
  assign slot_free = ~wr_en_q | ~fifo_full;

  always_comb begin
    state_d   = state_q;
    // A word leaving the slot with nothing behind it empties the slot.
    wr_en_d   = wr_en_q & ~accept;
    din_d     = din_q;
    seq_d     = seq_q;
    len_d     = len_q;
    pkt_cnt_d = pkt_cnt_q;
    s_ready   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable && s_valid && slot_free) begin
          wr_en_d = 1'b1;
          din_d   = {TagHdr, seq_q};
          state_d = StData;
        end
      end
      StData: begin
        s_ready = slot_free;
        if (s_valid && slot_free) begin
          wr_en_d = 1'b1;
          din_d   = {TagData, s_data};
          len_d   = (len_q == {DATA_WIDTH{1'b1}}) ? len_q : len_q + DATA_WIDTH'(1);
          if (s_last) begin
            state_d = StTrl;
          end
        end
      end
      StTrl: begin
        if (slot_free) begin
          wr_en_d   = 1'b1;
          din_d     = {TagTrl, len_q};
          seq_d     = seq_q + DATA_WIDTH'(1);
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          len_d     = '0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      wr_en_q   <= 1'b0;
      din_q     <= '0;
      seq_q     <= '0;
      len_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      din_q     <= din_d;
      seq_q     <= seq_d;
      len_q     <= len_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign fifo_wr_en = wr_en_q;
  assign fifo_din   = din_q;
  assign busy       = (state_q != StIdle);
  assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Bench for fifo_pkt_writer: directed framing cases plus randomized packets and
// backpressure checked against a packet-level model of the expected FIFO stream.
module tb_fifo_pkt_writer;

  logic       wr_clk;
  logic       rst;
  logic       enable;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       fifo_wr_en;
  logic [9:0] fifo_din;
  logic       fifo_full;
  logic       busy;
  logic [15:0] pkt_cnt;

  fifo_pkt_writer #(.DATA_WIDTH(8)) dut (
    .wr_clk     (wr_clk),
    .rst        (rst),
    .enable     (enable),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .pkt_cnt    (pkt_cnt)
  );

  int checks = 0;
  int failures = 0;

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  // Words the FIFO captured, and the cycle each was captured in.
  logic [9:0] got[$];
  int         got_cyc[$];
  int         cyc = 0;
  int         hold_viol = 0;
  logic       prev_stall = 1'b0;
  logic [9:0] prev_din;
  bit         rand_full = 0;

  always @(posedge wr_clk) cyc++;

  always @(negedge wr_clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (fifo_wr_en && !fifo_full) begin
        got.push_back(fifo_din);
        got_cyc.push_back(cyc);
      end
      if (prev_stall && (fifo_wr_en !== 1'b1 || fifo_din !== prev_din)) hold_viol++;
      if (fifo_wr_en && fifo_full && s_ready) hold_viol++;
      if (fifo_wr_en && fifo_din[9:8] == 2'b10) hold_viol++;
      prev_stall = fifo_wr_en && fifo_full;
      prev_din   = fifo_din;
    end
  end

  always @(posedge wr_clk) begin
    if (rand_full) begin
      #1;
      fifo_full = ($urandom_range(0, 3) == 0);
    end
  end

  // Packet-level model: header(seq), payload words, trailer(saturated length).
  logic [7:0] m_seq = 8'd0;
  int         m_pkts = 0;
  logic [9:0] exp_q[$];

  function automatic void model_pkt(input logic [8:0] w[$]);
    int         n;
    logic [7:0] lb;
    n = w.size();
    exp_q.push_back({2'b01, m_seq});
    foreach (w[i]) exp_q.push_back({2'b00, w[i][7:0]});
    if (w[n-1][8]) begin
      lb = (n > 255) ? 8'hFF : n[7:0];
      exp_q.push_back({2'b11, lb});
      m_seq = m_seq + 8'd1;
      m_pkts++;
    end
  endfunction

  task automatic apply_reset();
    @(posedge wr_clk);
    #3 rst = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    fifo_full = 1'b0;
    repeat (2) @(posedge wr_clk);
    #1 rst = 1'b0;
    got.delete();
    got_cyc.delete();
    exp_q.delete();
    m_seq = 8'd0;
    m_pkts = 0;
  endtask

  // Presents {last,data} words; optional bubbles after each accepted word.
  task automatic send_words(input logic [8:0] w[$], input int bubble_pct);
    logic hs;
    int   n;
    foreach (w[i]) begin
      s_valid = 1'b1;
      s_data  = w[i][7:0];
      s_last  = w[i][8];
      n = 0;
      hs = 1'b0;
      while (!hs) begin
        @(negedge wr_clk);
        hs = s_ready;
        @(posedge wr_clk);
        #1;
        if (!hs && ++n > 2000) begin
          checks++;
          failures++;
          $display("FAIL send_words: no handshake for word %0d after 2000 cycles, required one", i);
          s_valid = 1'b0;
          return;
        end
      end
      if (bubble_pct > 0 && $urandom_range(0, 99) < bubble_pct) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge wr_clk);
        #1;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    if (rand_full) begin
      rand_full = 0;
      @(posedge wr_clk);
      #1;
    end
    fifo_full = 1'b0;
    for (n = 0; n < 100; n++) begin
      @(negedge wr_clk);
      if (!fifo_wr_en && !busy) break;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL drain: busy=%0b wr_en=%0b after 100 cycles, required 0/0", busy, fifo_wr_en);
    end
    @(posedge wr_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({fifo_wr_en, fifo_din, s_ready, busy, pkt_cnt} !== 30'd0) begin
      failures++;
      $display("FAIL reset_init: wr_en=%b din=%h rdy=%b busy=%b cnt=%h, required all 0",
               fifo_wr_en, fifo_din, s_ready, busy, pkt_cnt);
    end
    @(posedge wr_clk);
    #1 rst = 1'b0;
    enable = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h12;
    s_last = 1'b0;
    repeat (3) @(posedge wr_clk);
    #1;
    checks++;
    if (busy !== 1'b1 || fifo_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre: busy=%b wr_en=%b, required 1/1", busy, fifo_wr_en);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({fifo_wr_en, fifo_din, s_ready, busy, pkt_cnt} !== 30'd0) begin
      failures++;
      $display("FAIL reset_async: wr_en=%b din=%h rdy=%b busy=%b cnt=%h, required all 0",
               fifo_wr_en, fifo_din, s_ready, busy, pkt_cnt);
    end
    repeat (3) begin
      @(negedge wr_clk);
      checks++;
      if (fifo_wr_en !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: wr_en=%b busy=%b, required 0/0", fifo_wr_en, busy);
      end
    end
    s_valid = 1'b0;
    @(posedge wr_clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [9:0] want[5];
    want = '{10'h100, 10'h0A1, 10'h0A2, 10'h0A3, 10'h303};
    apply_reset();
    enable = 1'b1;
    send_words('{9'h0A1, 9'h0A2, 9'h1A3}, 0);
    wait_idle();
    checks++;
    if (got.size() != 5) begin
      failures++;
      $display("FAIL basic_count: got %0d writes, required 5", got.size());
    end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== want[i] || got_cyc[i] != got_cyc[0] + i) begin
        failures++;
        $display("FAIL basic_word%0d: got %h at +%0d, required %h at +%0d",
                 i, got[i], got_cyc[i] - got_cyc[0], want[i], i);
      end
    end
    checks++;
    if (pkt_cnt !== 16'd1) begin
      failures++;
      $display("FAIL basic_pkt_cnt: got %0d, required 1", pkt_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] want[8];
    want = '{10'h100, 10'h0A1, 10'h0A2, 10'h0A3, 10'h303, 10'h101, 10'h055, 10'h301};
    apply_reset();
    enable = 1'b1;
    send_words('{9'h0A1, 9'h0A2, 9'h1A3, 9'h155}, 0);
    wait_idle();
    checks++;
    if (got.size() != 8) begin
      failures++;
      $display("FAIL b2b_count: got %0d writes, required 8", got.size());
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== want[i] || got_cyc[i] != got_cyc[0] + i) begin
        failures++;
        $display("FAIL b2b_word%0d: got %h at +%0d, required %h at +%0d",
                 i, got[i], got_cyc[i] - got_cyc[0], want[i], i);
      end
    end
    checks++;
    if (pkt_cnt !== 16'd2) begin
      failures++;
      $display("FAIL b2b_pkt_cnt: got %0d, required 2", pkt_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] want[5];
    want = '{10'h100, 10'h0A1, 10'h0A2, 10'h0A3, 10'h303};
    apply_reset();
    hold_viol = 0;
    enable = 1'b1;
    fork
      send_words('{9'h0A1, 9'h0A2, 9'h1A3}, 0);
      begin
        int n;
        for (n = 0; n < 50; n++) begin
          @(posedge wr_clk);
          #1;
          if (fifo_wr_en && fifo_din == 10'h0A2) break;
        end
        fifo_full = 1'b1;
        repeat (4) begin
          @(negedge wr_clk);
          checks++;
          if (fifo_wr_en !== 1'b1 || fifo_din !== 10'h0A2 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold: wr_en=%b din=%h rdy=%b, required 1/0a2/0",
                     fifo_wr_en, fifo_din, s_ready);
          end
        end
        @(posedge wr_clk);
        #1 fifo_full = 1'b0;
      end
    join
    wait_idle();
    checks++;
    if (got.size() != 5) begin
      failures++;
      $display("FAIL bp_count: got %0d writes, required 5", got.size());
    end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        failures++;
        $display("FAIL bp_word%0d: got %h, required %h", i, got[i], want[i]);
      end
    end
    checks++;
    if (hold_viol != 0 || pkt_cnt !== 16'd1) begin
      failures++;
      $display("FAIL bp_status: hold_viol=%0d pkt_cnt=%0d, required 0/1", hold_viol, pkt_cnt);
    end
  endtask

  task automatic test_enable();
    logic [8:0] w[$];
    apply_reset();
    w = '{9'h011, 9'h022, 9'h133};
    model_pkt(w);
    enable = 1'b0;
    fork
      send_words(w, 0);
      begin
        repeat (5) begin
          @(negedge wr_clk);
          checks++;
          if (fifo_wr_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL en_block: wr_en=%b busy=%b, required 0/0", fifo_wr_en, busy);
          end
        end
        @(posedge wr_clk);
        #1 enable = 1'b1;
        for (int n = 0; n < 20 && !busy; n++) @(posedge wr_clk);
        #1 enable = 1'b0;
      end
    join
    wait_idle();
    checks++;
    if (got.size() != exp_q.size()) begin
      failures++;
      $display("FAIL en_count: got %0d writes, required %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL en_word%0d: got %h, required %h", i, got[i], exp_q[i]);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_random();
    logic [8:0] w[$];
    int         len;
    apply_reset();
    hold_viol = 0;
    enable = 1'b1;
    rand_full = 1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 6);
      w.delete();
      for (int i = 0; i < len; i++) w.push_back({(i == len - 1), 8'($urandom)});
      model_pkt(w);
      send_words(w, 30);
    end
    wait_idle();
    checks++;
    if (got.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_count: got %0d writes, required %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rand_word%0d: got %h, required %h", i, got[i], exp_q[i]);
      end
    end
    checks++;
    if (hold_viol != 0 || pkt_cnt !== 16'(m_pkts)) begin
      failures++;
      $display("FAIL rand_status: hold_viol=%0d pkt_cnt=%0d, required 0/%0d",
               hold_viol, pkt_cnt, m_pkts);
    end
  endtask

  task automatic test_saturation_wrap();
    logic [8:0] w[$];
    apply_reset();
    enable = 1'b1;
    for (int i = 0; i < 300; i++) w.push_back({(i == 299), 8'($urandom)});
    model_pkt(w);
    send_words(w, 0);
    for (int p = 0; p < 256; p++) begin
      w.delete();
      w.push_back({1'b1, 8'($urandom)});
      model_pkt(w);
      send_words(w, 0);
    end
    wait_idle();
    checks++;
    if (got.size() != exp_q.size()) begin
      failures++;
      $display("FAIL sat_count: got %0d writes, required %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL sat_word%0d: got %h, required %h", i, got[i], exp_q[i]);
      end
    end
    checks++;
    if (got.size() < 1068 || got[301] !== 10'h3FF || got[1067] !== 10'h100) begin
      failures++;
      $display("FAIL sat_wrap: size=%0d trl=%h hdr257=%h, required >=1068/3ff/100",
               got.size(), (got.size() > 301) ? got[301] : 10'h0,
               (got.size() > 1067) ? got[1067] : 10'h0);
    end
    checks++;
    if (pkt_cnt !== 16'd257) begin
      failures++;
      $display("FAIL sat_pkt_cnt: got %0d, required 257", pkt_cnt);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [9:0] pre[3];
    logic [9:0] post[3];
    int         n;
    pre  = '{10'h100, 10'h061, 10'h062};
    post = '{10'h100, 10'h077, 10'h301};
    apply_reset();
    enable = 1'b1;
    send_words('{9'h061, 9'h062}, 0);
    for (n = 0; n < 20 && fifo_wr_en; n++) @(negedge wr_clk);
    checks++;
    if (busy !== 1'b1 || fifo_wr_en !== 1'b0 || got.size() != 3) begin
      failures++;
      $display("FAIL mid_pre: busy=%b wr_en=%b writes=%0d, required 1/0/3",
               busy, fifo_wr_en, got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== pre[i]) begin
        failures++;
        $display("FAIL mid_pre_word%0d: got %h, required %h", i, got[i], pre[i]);
      end
    end
    apply_reset();
    send_words('{9'h177}, 0);
    wait_idle();
    checks++;
    if (got.size() != 3) begin
      failures++;
      $display("FAIL mid_post_count: got %0d writes, required 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== post[i]) begin
        failures++;
        $display("FAIL mid_post_word%0d: got %h, required %h", i, got[i], post[i]);
      end
    end
    checks++;
    if (pkt_cnt !== 16'd1) begin
      failures++;
      $display("FAIL mid_pkt_cnt: got %0d, required 1", pkt_cnt);
    end
  endtask

  initial begin
    rst = 1'b0;
    enable = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    s_last = 1'b0;
    fifo_full = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_enable();
    test_random();
    test_saturation_wrap();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
